// File: rtl/wb_prospect_queue_pkg.sv
// Shared widths, types and tag-compare helpers for the writeback prospect queue.
// Optional build macro used by the queue: WB_PROSPECT_STATS_EN (push-stall counter).
package wb_prospect_queue_pkg;

    localparam int PTC_SLOT_W      = 16;
    localparam int LANES_PER_ENTRY = 8;
    localparam int DATA_W          = 64;
    localparam int PTC_W           = 128;

    typedef logic [PTC_SLOT_W-1:0]      ptc_tag_t;
    typedef logic [LANES_PER_ENTRY-1:0] lane_mask_t;

    // One physical slot: occupancy flag, 8 data bytes and 8 lane tags.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [PTC_W-1:0]  ptc;
    } entry_t;

    // Lanes of a stored entry whose nonzero tag is also carried by an incoming push.
    // A zero stored tag never hits, so a zero incoming tag can never clear anything.
    function automatic lane_mask_t supersede_mask(input logic [PTC_W-1:0] stored,
                                                  input logic [PTC_W-1:0] incoming);
        lane_mask_t m;
        m = '0;
        for (int i = 0; i < LANES_PER_ENTRY; i++) begin
            for (int j = 0; j < LANES_PER_ENTRY; j++) begin
                if ((stored[i*PTC_SLOT_W +: PTC_SLOT_W] != '0) &&
                    (stored[i*PTC_SLOT_W +: PTC_SLOT_W] == incoming[j*PTC_SLOT_W +: PTC_SLOT_W]))
                    m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Zero the tag of every lane selected by the mask; data is untouched.
    function automatic logic [PTC_W-1:0] clear_lanes(input logic [PTC_W-1:0] ptc,
                                                     input lane_mask_t      m);
        logic [PTC_W-1:0] r;
        r = ptc;
        for (int i = 0; i < LANES_PER_ENTRY; i++) begin
            if (m[i])
                r[i*PTC_SLOT_W +: PTC_SLOT_W] = '0;
        end
        return r;
    endfunction

    // A push that carries the same nonzero tag in several lanes keeps only the
    // highest such lane, so a tag is never duplicated inside one entry either.
    function automatic logic [PTC_W-1:0] dedup_ptc(input logic [PTC_W-1:0] incoming);
        logic [PTC_W-1:0] r;
        r = incoming;
        for (int j = 0; j < LANES_PER_ENTRY; j++) begin
            for (int k = j + 1; k < LANES_PER_ENTRY; k++) begin
                if ((incoming[j*PTC_SLOT_W +: PTC_SLOT_W] != '0) &&
                    (incoming[j*PTC_SLOT_W +: PTC_SLOT_W] == incoming[k*PTC_SLOT_W +: PTC_SLOT_W]))
                    r[j*PTC_SLOT_W +: PTC_SLOT_W] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_prospect_queue_if.sv
// Push/retire bundle of the writeback prospect queue.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; valid may not depend on ready, and enq_ready never depends on deq_ready.
interface wb_prospect_queue_if;
    import wb_prospect_queue_pkg::*;

    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_data;
    logic [PTC_W-1:0]  enq_ptc;

    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_data;
    logic [PTC_W-1:0]  deq_ptc;

    // Writeback unit / register-file side.
    modport master (
        output enq_valid, enq_data, enq_ptc, deq_ready,
        input  enq_ready, deq_valid, deq_data, deq_ptc
    );

    // Queue side.
    modport slave (
        input  enq_valid, enq_data, enq_ptc, deq_ready,
        output enq_ready, deq_valid, deq_data, deq_ptc
    );

endinterface

// File: rtl/wb_prospect_entry.sv
// One queue slot: 64 data bits plus eight 16-bit lane tags, with the 8x8 lane
// comparators that clear tags superseded by a newer push.
module wb_prospect_entry
    import wb_prospect_queue_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [PTC_W-1:0]  i_wr_ptc,
    input  logic              i_sup_en,
    input  logic [PTC_W-1:0]  i_sup_ptc,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [PTC_W-1:0]  o_ptc
);

    entry_t           r_ent;
    lane_mask_t       w_hit;
    logic [PTC_W-1:0] w_sup_ptc;

    // Tags this slot keeps after an accepted push elsewhere in the queue.
    always_comb begin
        w_hit     = i_sup_en ? supersede_mask(r_ent.ptc, i_sup_ptc) : '0;
        w_sup_ptc = clear_lanes(r_ent.ptc, w_hit);
    end

    // Slot state: a write replaces the whole entry; otherwise apply supersession
    // and drop occupancy when this slot is the head being retired.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ent <= '0;
        end else if (i_flush) begin
            r_ent <= '0;
        end else if (i_wr) begin
            r_ent <= '{valid: 1'b1, data: i_wr_data, ptc: i_wr_ptc};
        end else begin
            r_ent.ptc <= w_sup_ptc;
            if (i_pop)
                r_ent.valid <= 1'b0;
        end
    end

    assign o_valid = r_ent.valid;
    assign o_data  = r_ent.data;
    assign o_ptc   = r_ent.ptc;

endmodule

// File: rtl/wb_prospect_queue.sv
// Writeback prospect queue: circular FIFO of writeback results whose slots are
// also exposed as bypass candidates, with newer pushes superseding older tags so
// every nonzero tag is live in at most one lane.
// Optional build macro: WB_PROSPECT_STATS_EN adds the saturating stall_cnt output.
module wb_prospect_queue
    import wb_prospect_queue_pkg::*;
#(
    parameter int NUM_PROSPECTS = 4
) (
    input  logic                            clk,
    input  logic                            clr,
    wb_prospect_queue_if.slave              bus,
    input  logic                            flush,
    output logic [NUM_PROSPECTS*DATA_W-1:0] prospective_data,
    output logic [NUM_PROSPECTS*PTC_W-1:0]  prospective_ptc,
    output logic [$clog2(NUM_PROSPECTS):0]  count
`ifdef WB_PROSPECT_STATS_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_PROSPECTS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PROSPECTS);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq_ready;
    logic             w_deq_valid;
    logic             w_push;
    logic             w_pop;
    logic [PTC_W-1:0] w_wr_ptc;

    logic              w_valid [NUM_PROSPECTS];
    logic [DATA_W-1:0] w_data  [NUM_PROSPECTS];
    logic [PTC_W-1:0]  w_ptc   [NUM_PROSPECTS];

    // Ready depends only on occupancy, so a full queue refuses a push even when
    // the head retires in the same cycle. Flush swallows any push or pop.
    assign w_enq_ready = (r_count < FULL_CNT);
    assign w_deq_valid = (r_count != '0);
    assign w_push      = bus.enq_valid & w_enq_ready & ~flush;
    assign w_pop       = w_deq_valid & bus.deq_ready & ~flush;
    assign w_wr_ptc    = dedup_ptc(bus.enq_ptc);

    assign bus.enq_ready = w_enq_ready;
    assign bus.deq_valid = w_deq_valid;
    assign bus.deq_data  = w_data[r_head];
    assign bus.deq_ptc   = w_ptc[r_head];
    assign count         = r_count;

    for (genvar g = 0; g < NUM_PROSPECTS; g++) begin : g_slot
        logic w_slot_wr;
        logic w_slot_pop;

        assign w_slot_wr  = w_push && (r_tail == PTR_W'(g));
        assign w_slot_pop = w_pop  && (r_head == PTR_W'(g));

        wb_prospect_entry u_entry (
            .clk       (clk),
            .clr       (clr),
            .i_flush   (flush),
            .i_wr      (w_slot_wr),
            .i_wr_data (bus.enq_data),
            .i_wr_ptc  (w_wr_ptc),
            .i_sup_en  (w_push),
            .i_sup_ptc (bus.enq_ptc),
            .i_pop     (w_slot_pop),
            .o_valid   (w_valid[g]),
            .o_data    (w_data[g]),
            .o_ptc     (w_ptc[g])
        );

        // Unoccupied slots present zeros so stale tags never reach the bypass mux.
        assign prospective_data[g*DATA_W +: DATA_W] = w_valid[g] ? w_data[g] : '0;
        assign prospective_ptc[g*PTC_W +: PTC_W]    = w_valid[g] ? w_ptc[g]  : '0;
    end

    // Head/tail pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WB_PROSPECT_STATS_EN
    logic [15:0] r_stall_cnt;

    // Cycles a push was offered but refused; saturates, survives flush.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            r_stall_cnt <= '0;
        else if (bus.enq_valid && !w_enq_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
